// File: rtl/ides_align_pkg.sv
// ides_align_pkg: shared state encoding, default parameters and counter widths for ides_align_ctrl
package ides_align_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SLIP,
      SETTLE,
      LOCKED,
      FAIL
   } state_t;

   localparam logic [15:0] DEF_PATTERN   = 16'h00FF;
   localparam int          DEF_MATCH_CNT = 8;
   localparam int          DEF_CALIB_GAP = 4;
   localparam int          DEF_LOSS_CNT  = 4;
   localparam int          SLIP_W        = 5;

endpackage

// File: rtl/ides_align_cnt.sv
// ides_align_cnt: saturating up-counter with synchronous clear and a terminal-count flag
module ides_align_cnt #(
   parameter int W   = 8,
   parameter int MAX = 255
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   // clear wins over increment; increment holds once MAX is reached
   always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != MAX_V) ? cnt_q + W'(1) : cnt_q;

   // count register
   always_ff @(posedge clk or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;

   assign cnt_o = cnt_q;
   assign tc_o  = cnt_q == MAX_V;

endmodule

// File: rtl/ides_align_ctrl.sv
// ides_align_ctrl: word-alignment FSM driving deserializer CALIB slips until PATTERN locks.
// Define IDES_ALIGN_MONITOR_EN to keep comparing in LOCKED and relock after LOSS_CNT misses.
module ides_align_ctrl
   import ides_align_pkg::*;
#(
   parameter int          WIDTH     = 16,
   parameter logic [15:0] PATTERN   = DEF_PATTERN,
   parameter int          MATCH_CNT = DEF_MATCH_CNT,
   parameter int          CALIB_GAP = DEF_CALIB_GAP,
   parameter int          LOSS_CNT  = DEF_LOSS_CNT
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [WIDTH-1:0]  word_i,
   output logic              calib_o,
   output logic              busy_o,
   output logic              locked_o,
   output logic              fail_o,
   output logic [SLIP_W-1:0] slip_cnt_o,
   output logic              relock_o
);

   state_t state_q, state_d;
   logic calib_q, calib_d, busy_q, busy_d, locked_q, locked_d, fail_q, fail_d, relock_q, relock_d;
   logic match, restart, in_check;
   logic match_tc, gap_tc, slip_tc;
   logic [7:0] match_cnt;
   logic [3:0] gap_cnt;
   logic [SLIP_W-1:0] slip_cnt;
   logic unused_cnt;

   assign match    = word_i == PATTERN[WIDTH-1:0];
   assign restart  = start_i && (state_q inside {IDLE, FAIL, LOCKED});
   assign in_check = state_q == CHECK;

   // match_cnt tc fires at MATCH_CNT-1 so the final matching word locks on the same edge
   ides_align_cnt #(.W(8), .MAX(MATCH_CNT - 1)) u_match (
      .clk(clk), .rst_ni(rst_ni),
      .clr_i(restart || relock_d || (in_check && !match)),
      .inc_i(in_check && match),
      .cnt_o(match_cnt), .tc_o(match_tc)
   );

   ides_align_cnt #(.W(4), .MAX(CALIB_GAP - 1)) u_gap (
      .clk(clk), .rst_ni(rst_ni),
      .clr_i(restart || state_q == SLIP),
      .inc_i(state_q == SETTLE),
      .cnt_o(gap_cnt), .tc_o(gap_tc)
   );

   ides_align_cnt #(.W(SLIP_W), .MAX(WIDTH)) u_slip (
      .clk(clk), .rst_ni(rst_ni),
      .clr_i(restart || relock_d),
      .inc_i(state_q == SLIP),
      .cnt_o(slip_cnt), .tc_o(slip_tc)
   );

`ifdef IDES_ALIGN_MONITOR_EN
   logic       loss_tc;
   logic [3:0] loss_cnt;

   // consecutive mismatches seen while locked; any match or leaving LOCKED clears it
   ides_align_cnt #(.W(4), .MAX(LOSS_CNT - 1)) u_loss (
      .clk(clk), .rst_ni(rst_ni),
      .clr_i(restart || relock_d || state_q != LOCKED || match),
      .inc_i(state_q == LOCKED && !match),
      .cnt_o(loss_cnt), .tc_o(loss_tc)
   );

   assign unused_cnt = ^{match_cnt, gap_cnt, loss_cnt};
`else
   assign unused_cnt = ^{match_cnt, gap_cnt, 32'(LOSS_CNT)};
`endif

   // next state, with outputs derived from the next state so they register alongside it
   always_comb begin
      state_d  = state_q;
      relock_d = 1'b0;
      case (state_q)
         IDLE, FAIL: state_d = start_i ? CHECK : state_q;
         CHECK:      state_d = !match ? (slip_tc ? FAIL : SLIP) : (match_tc ? LOCKED : CHECK);
         SLIP:       state_d = SETTLE;
         SETTLE:     state_d = gap_tc ? CHECK : SETTLE;
         LOCKED: begin
`ifdef IDES_ALIGN_MONITOR_EN
            relock_d = !start_i && !match && loss_tc;
`endif
            state_d  = (start_i || relock_d) ? CHECK : LOCKED;
         end
         default:    state_d = IDLE;
      endcase
      calib_d  = state_d == SLIP;
      busy_d   = state_d inside {CHECK, SLIP, SETTLE};
      locked_d = state_d == LOCKED;
      fail_d   = state_d == FAIL;
   end

   // state and output registers; reset aborts any CALIB pulse in flight
   always_ff @(posedge clk or negedge rst_ni)
      if (!rst_ni) begin
         state_q  <= IDLE;
         calib_q  <= 1'b0;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
         fail_q   <= 1'b0;
         relock_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         calib_q  <= calib_d;
         busy_q   <= busy_d;
         locked_q <= locked_d;
         fail_q   <= fail_d;
         relock_q <= relock_d;
      end

   assign calib_o    = calib_q;
   assign busy_o     = busy_q;
   assign locked_o   = locked_q;
   assign fail_o     = fail_q;
   assign relock_o   = relock_q;
   assign slip_cnt_o = slip_cnt;

endmodule

// File: tb/tb_ides_align_ctrl.sv
// tb_ides_align_ctrl: vector table plus directed multi-cycle sequences for ides_align_ctrl
module tb_ides_align_ctrl;

   localparam logic [15:0] PAT = 16'h00FF;

   typedef struct {
      logic        s;
      logic [15:0] w;
      logic [9:0]  e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] word_i = '0;
   logic        calib_o, busy_o, locked_o, fail_o, relock_o;
   logic [4:0]  slip_cnt_o;

   int   errs = 0;
   int   checks = 0;
   vec_t tbl[$];

   ides_align_ctrl dut (
      .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .word_i(word_i),
      .calib_o(calib_o), .busy_o(busy_o), .locked_o(locked_o), .fail_o(fail_o),
      .slip_cnt_o(slip_cnt_o), .relock_o(relock_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [9:0] outs();
      return {calib_o, busy_o, locked_o, fail_o, relock_o, slip_cnt_o};
   endfunction

   function automatic logic [15:0] rotl(input int k);
      logic [15:0] p = PAT;
      return (p << k) | (p >> (16 - k));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic [15:0] w, input logic c, input logic b,
                      input logic l, input logic f, input logic [4:0] sl);
      tbl.push_back('{s, w, {c, b, l, f, 1'b0, sl}});
   endtask

   task automatic wait_lock(input string nm);
      int n = 0;
      while (!locked_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(nm, locked_o, 1);
   endtask

   initial begin
      int n, pulses, last, gap_bad, off;

      // aligned lock, sticky lock, restart, 7 matches then a mismatch, ignored start in SETTLE, relock
      add(1, PAT, 0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) add(0, PAT, 0, 1, 0, 0, 0);
      add(0, PAT, 0, 0, 1, 0, 0);
      add(0, PAT, 0, 0, 1, 0, 0);
      add(1, PAT, 0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) add(0, PAT, 0, 1, 0, 0, 0);
      add(0, 16'h0000, 1, 1, 0, 0, 0);
      add(0, PAT, 0, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 1, 0, 0, 1);
      add(1, PAT, 0, 1, 0, 0, 1);
      add(0, PAT, 0, 1, 0, 0, 1);
      add(0, PAT, 0, 1, 0, 0, 1);
      for (int i = 0; i < 7; i++) add(0, PAT, 0, 1, 0, 0, 1);
      add(0, PAT, 0, 0, 1, 0, 1);

      repeat (2) @(negedge clk);
      chk("reset_state", outs(), 10'h0);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", outs(), 10'h0);

      foreach (tbl[i]) begin
         start_i = tbl[i].s;
         word_i  = tbl[i].w;
         @(negedge clk);
         chk($sformatf("vec%0d", i), outs(), tbl[i].e);
      end
      start_i = 1'b0;

      // rotated input: one rotation undone per CALIB, starting 5 positions off
      off = 5;
      word_i = rotl(off);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0; pulses = 0; last = -100; gap_bad = 0;
      while (!locked_o && n < 300) begin
         if (calib_o) begin
            pulses++;
            if (n - last < 6) gap_bad++;
            last = n;
            if (off > 0) off--;
            word_i = rotl(off);
         end
         @(negedge clk);
         n++;
      end
      chk("rot_locked", locked_o, 1);
      chk("rot_pulses", pulses, 5);
      chk("rot_slip_cnt", slip_cnt_o, 5);
      chk("rot_gap_violations", gap_bad, 0);

      // no pattern: every slip tried, then FAIL until restarted
      word_i = 16'h0000;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0; pulses = 0;
      while (!fail_o && n < 300) begin
         if (calib_o) pulses++;
         @(negedge clk);
         n++;
      end
      chk("nop_fail", fail_o, 1);
      chk("nop_pulses", pulses, 16);
      chk("nop_latency_bound", n <= 98, 1);
      chk("nop_outs", outs(), {5'b00010, 5'd16});
      repeat (2) @(negedge clk);
      chk("nop_fail_held", outs(), {5'b00010, 5'd16});
      word_i = PAT;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("nop_restart", outs(), {5'b01000, 5'd0});
      wait_lock("nop_relock");

`ifdef IDES_ALIGN_MONITOR_EN
      // three misses then a match keeps lock
      word_i = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mon_hold%0d", i), {locked_o, relock_o}, 2'b10);
      end
      word_i = PAT;
      @(negedge clk);
      chk("mon_hold_match", {locked_o, relock_o}, 2'b10);
      // four misses: relock pulse with locked dropping on the same cycle
      word_i = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mon_loss%0d", i), {locked_o, relock_o}, 2'b10);
      end
      @(negedge clk);
      chk("mon_relock", {relock_o, locked_o, busy_o, slip_cnt_o}, {3'b101, 5'd0});
      word_i = PAT;
      @(negedge clk);
      chk("mon_relock_pulse", relock_o, 0);
      wait_lock("mon_realign");
`else
      // without the monitor, lock ignores the word stream
      word_i = 16'h0000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("sticky%0d", i), {locked_o, relock_o, busy_o}, 3'b100);
      end
      word_i = PAT;
`endif

      // asynchronous reset during the second CALIB pulse
      word_i = 16'h0000;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (!(calib_o && slip_cnt_o == 5'd1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_pre_calib", calib_o, 1);
      chk("rst_pre_slip", slip_cnt_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("rst_async", outs(), 10'h0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("rst_idle", outs(), 10'h0);
      word_i = PAT;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_lock("rst_lock");
      chk("rst_lock_slip", slip_cnt_o, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
